keyboard_event_arbiter: RTL and testbench
=========================================

# keyboard_event_arbiter

Shares the single keyboard event port (`keypress`/`keycode`/`shift_state`) of the SPMMIO keyboard FIFO between three event sources: PS/2 decoder, debug-UART key injection, and the on-board overlay. The block round-robins among sources with a valid/ready handshake. Credit tracking against the FIFO occupancy prevents overflow, and a programmable minimum gap paces the events. It sits between the sources and the keyboard MMIO block, and watches that block's read strobe.

## Interface
- `FIFO_DEPTH`, default 8: entries in the downstream keyboard FIFO; legal range 1..15.
- `MIN_GAP`, default 0: idle cycles forced after each grant before the next grant; legal range 0..15.

- `clk`  in  1  clock.
- `reset`  in  1  reset. One clock; reset is asynchronous and active-high.
- `req_valid`  in  [0:2]  per-source event valid; bit 0 is source 0.
- `req_keycode`  in  [0:20]  source n keycode at bits [7n:7n+6].
- `req_shift`  in  [0:11]  source n shift state at bits [4n:4n+3].
- `req_ready`  out  [0:2]  one-hot grant; combinational from state and `req_valid`.
- `fifo_pop`  in  1  one-cycle pulse when the keyboard FIFO read strobe fires (read of register 0).
- `keypress`  out  1  registered one-cycle event pulse to the FIFO.
- `keycode`  out  [0:6]  registered keycode, valid with `keypress`.
- `shift_state`  out  [0:3]  registered shift state, valid with `keypress`.
- `fifo_used`  out  [0:3]  arbiter's count of occupied FIFO entries.

## Operation
- Registers:
  - `used` (0..FIFO_DEPTH), shown on `fifo_used`.
  - `gap` counter.
  - `last` (index of the last granted source, 0..2).
  - Output registers `keypress`, `keycode`, `shift_state`.
- Grant condition, evaluated combinationally each cycle: `gap == 0`, `used + keypress < FIFO_DEPTH`, and at least one `req_valid` bit set.
- Arbitration: when the grant condition holds, search in order `last+1`, `last+2`, `last` (mod 3). The first source with valid set is granted.
  - Only that source's `req_ready` bit is high.
  - The transfer completes in the same cycle (valid && ready).
- On a grant:
  - Next edge: `keypress<=1`, `keycode`/`shift_state` <= the granted source's fields, `last` <= granted index, `gap` <= `MIN_GAP`.
- With no grant: `keypress<=0`. `keycode`/`shift_state` hold their previous values. If `gap > 0`, `gap` decrements.
- `used` update per edge, driven by the registered `keypress` and by `fifo_pop`:
  - keypress only: +1.
  - pop only with `used > 0`: -1.
  - pop only with `used == 0`: unchanged; an empty-FIFO read is ignored.
  - keypress and pop with `used > 0`: unchanged.
  - keypress and pop with `used == 0`: becomes 1.
- `used` never exceeds `FIFO_DEPTH`. This holds by construction, because the grant condition counts the in-flight `keypress`.
- Sources must hold their fields stable while valid is high and ready is low. The arbiter samples the fields only in the grant cycle.

## Timing
- Reset, asynchronous, effective immediately:
  - `keypress=0`, `keycode=0`, `shift_state=0`, `used=0`, `gap=0`, `last=2` (so source 0 wins first).
  - `req_ready=0` while `reset` is high.
- Latency: a grant in cycle t gives `keypress` high in cycle t+1; `used` reflects the event from cycle t+2.
- Throughput:
  - `MIN_GAP=0`: one event per cycle.
  - Otherwise: one event every `MIN_GAP+1` cycles.
- Full: with `used + keypress == FIFO_DEPTH`, all `req_ready` bits are 0. A pop at cycle t enables a grant at t+1.
- Reset mid-operation: any in-flight `keypress` is discarded and `used` clears. The downstream FIFO shares the same reset, so the two stay consistent.
- `req_ready` must never be asserted for a source whose `req_valid` is low.

## Test plan
- Single source: after reset, assert `req_valid[1]` with keycode 7'h2A and shift 4'h3 for one cycle.
  - `req_ready=3'b010` in that cycle.
  - Next cycle: `keypress=1`, `keycode=7'h2A`, `shift_state=4'h3`.
  - `fifo_used` becomes 1 one cycle later.
- Round-robin: hold all three valid with `MIN_GAP=0`. Grants are 0,1,2,0,1,2,… on consecutive cycles.
- Full: `FIFO_DEPTH=8`, source 0 continuously valid, no pops.
  - Exactly 8 keypress pulses, then ready stays 0 and `fifo_used=8`.
  - One `fifo_pop` leads to exactly one more pulse, and `fifo_used` returns to 8.
- Gap pacing: `MIN_GAP=3`, one source continuously valid. Keypress pulses are exactly 4 cycles apart.
- Boundary pops:
  - `fifo_pop` with `used=0` leaves `used=0`.
  - Pop coincident with keypress at `used=5` leaves 5.
  - Pop coincident with keypress at `used=0` gives 1.
- Reset mid-burst: assert `reset` while `keypress=1` and `used=4`.
  - All outputs are 0 immediately.
  - After release, source 0 wins first.

Source files
------------

// File: rtl/keyboard_event_arbiter_if.sv
// Keyboard event port shared between three event sources and the keyboard FIFO.
// The arbiter uses the slave modport; whoever drives the sources uses master.
interface keyboard_event_arbiter_if;
    logic [0:2]  req_valid;
    logic [0:20] req_keycode;
    logic [0:11] req_shift;
    logic [0:2]  req_ready;
    logic        fifo_pop;
    logic        keypress;
    logic [0:6]  keycode;
    logic [0:3]  shift_state;
    logic [0:3]  fifo_used;

    modport slave (
        input  req_valid, req_keycode, req_shift, fifo_pop,
        output req_ready, keypress, keycode, shift_state, fifo_used
    );

    modport master (
        output req_valid, req_keycode, req_shift, fifo_pop,
        input  req_ready, keypress, keycode, shift_state, fifo_used
    );
endinterface

// File: rtl/keyboard_event_arbiter.sv
// Round-robin arbiter for three keyboard event sources feeding one FIFO port,
// with credit tracking against FIFO occupancy and a programmable inter-event gap.
module keyboard_event_arbiter #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MIN_GAP    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    keyboard_event_arbiter_if.slave  bus
);

    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);
    localparam logic [3:0] GAP_C   = 4'(MIN_GAP);

    logic [3:0] used_q, used_d;
    logic [3:0] gap_q, gap_d;
    logic [1:0] last_q, last_d;
    logic       kp_q, kp_d;
    logic [6:0] kc_q, kc_d;
    logic [3:0] sh_q, sh_d;

    logic       grant_ok_s;
    logic       gnt_vld_s;
    logic [1:0] gnt_idx_s;
    logic [1:0] p0_s, p1_s, p2_s;
    logic [0:2] ready_s;
    logic [6:0] kc_sel_s;
    logic [3:0] sh_sel_s;

    // Round-robin search order starting just after the last granted source.
    always_comb begin
        p0_s = 2'd0;
        p1_s = 2'd1;
        p2_s = 2'd2;
        case (last_q)
            2'd0: begin p0_s = 2'd1; p1_s = 2'd2; p2_s = 2'd0; end
            2'd1: begin p0_s = 2'd2; p1_s = 2'd0; p2_s = 2'd1; end
            default: begin p0_s = 2'd0; p1_s = 2'd1; p2_s = 2'd2; end
        endcase
    end

    // Grant selection; the in-flight keypress counts as an occupied entry.
    always_comb begin
        gnt_vld_s  = 1'b0;
        gnt_idx_s  = 2'd0;
        ready_s    = 3'b000;
        grant_ok_s = !reset && (gap_q == 4'd0) &&
                     (({1'b0, used_q} + {4'd0, kp_q}) < DEPTH_C);
        if (grant_ok_s) begin
            if (bus.req_valid[p0_s]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = p0_s;
            end else if (bus.req_valid[p1_s]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = p1_s;
            end else if (bus.req_valid[p2_s]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = p2_s;
            end else begin
                gnt_vld_s = 1'b0;
            end
        end else begin
            gnt_vld_s = 1'b0;
        end
        if (gnt_vld_s) begin
            ready_s[gnt_idx_s] = 1'b1;
        end else begin
            ready_s = 3'b000;
        end
    end

    // Field mux for the granted source.
    always_comb begin
        kc_sel_s = bus.req_keycode[0:6];
        sh_sel_s = bus.req_shift[0:3];
        case (gnt_idx_s)
            2'd0: begin kc_sel_s = bus.req_keycode[0:6];   sh_sel_s = bus.req_shift[0:3];  end
            2'd1: begin kc_sel_s = bus.req_keycode[7:13];  sh_sel_s = bus.req_shift[4:7];  end
            default: begin kc_sel_s = bus.req_keycode[14:20]; sh_sel_s = bus.req_shift[8:11]; end
        endcase
    end

    // Next-state for event outputs, gap pacing and round-robin pointer.
    always_comb begin
        kp_d   = 1'b0;
        kc_d   = kc_q;
        sh_d   = sh_q;
        last_d = last_q;
        gap_d  = gap_q;
        if (gnt_vld_s) begin
            kp_d   = 1'b1;
            kc_d   = kc_sel_s;
            sh_d   = sh_sel_s;
            last_d = gnt_idx_s;
            gap_d  = GAP_C;
        end else if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end else begin
            gap_d = gap_q;
        end
    end

    // Occupancy credit: a pop on an empty FIFO is ignored.
    always_comb begin
        used_d = used_q;
        case ({kp_q, bus.fifo_pop})
            2'b10: used_d = used_q + 4'd1;
            2'b01: begin
                if (used_q != 4'd0) begin
                    used_d = used_q - 4'd1;
                end else begin
                    used_d = used_q;
                end
            end
            2'b11: begin
                if (used_q == 4'd0) begin
                    used_d = 4'd1;
                end else begin
                    used_d = used_q;
                end
            end
            default: used_d = used_q;
        endcase
    end

    // State registers; last resets to 2 so source 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            used_q <= 4'd0;
            gap_q  <= 4'd0;
            last_q <= 2'd2;
            kp_q   <= 1'b0;
            kc_q   <= 7'd0;
            sh_q   <= 4'd0;
        end else begin
            used_q <= used_d;
            gap_q  <= gap_d;
            last_q <= last_d;
            kp_q   <= kp_d;
            kc_q   <= kc_d;
            sh_q   <= sh_d;
        end
    end

    assign bus.req_ready   = ready_s;
    assign bus.keypress    = kp_q;
    assign bus.keycode     = kc_q;
    assign bus.shift_state = sh_q;
    assign bus.fifo_used   = used_q;

endmodule

// File: tb/tb_keyboard_event_arbiter.sv
// Scoreboard bench: expected events are queued as stimulus is applied and
// compared as keypress pulses appear; dut_b runs with MIN_GAP=3 for pacing.
module tb_keyboard_event_arbiter;

    logic clk;
    logic reset;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic [10:0] qa[$];

    keyboard_event_arbiter_if ifa();
    keyboard_event_arbiter_if ifb();

    keyboard_event_arbiter #(.FIFO_DEPTH(8), .MIN_GAP(0)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    keyboard_event_arbiter #(.FIFO_DEPTH(8), .MIN_GAP(3)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    always #5 clk = ~clk;

    // Scoreboard monitor for dut_a event output.
    always @(negedge clk) begin
        if (!reset && ifa.keypress) begin
            total_cnt = total_cnt + 1;
            if (qa.size() == 0) begin
                $display("FAIL unexpected_keypress: got code=%0h shift=%0h, expected no event",
                         ifa.keycode, ifa.shift_state);
            end else begin
                logic [10:0] exp_v;
                exp_v = qa.pop_front();
                if ({ifa.keycode, ifa.shift_state} !== exp_v) begin
                    $display("FAIL event_payload: got %0h expected %0h",
                             {ifa.keycode, ifa.shift_state}, exp_v);
                end else begin
                    pass_cnt = pass_cnt + 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_src_a(input int n, input logic [6:0] kc, input logic [3:0] sh);
        ifa.req_keycode[7*n +: 7] = kc;
        ifa.req_shift[4*n +: 4]   = sh;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        ifa.req_valid = 3'b000;
        ifa.fifo_pop  = 1'b0;
        ifb.req_valid = 3'b000;
        ifb.fifo_pop  = 1'b0;
        qa.delete();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_empty(input string name);
        total_cnt = total_cnt + 1;
        if (qa.size() != 0) $display("FAIL %s: got %0d pending events expected 0", name, qa.size());
        else pass_cnt = pass_cnt + 1;
    endtask

    task automatic test_reset;
        ifa.req_valid = 3'b111;
        #1;
        total_cnt = total_cnt + 5;
        if (ifa.keypress !== 1'b0) $display("FAIL rst_keypress: got %0b expected 0", ifa.keypress);
        else pass_cnt = pass_cnt + 1;
        if (ifa.keycode !== 7'h00) $display("FAIL rst_keycode: got %0h expected 0", ifa.keycode);
        else pass_cnt = pass_cnt + 1;
        if (ifa.shift_state !== 4'h0) $display("FAIL rst_shift: got %0h expected 0", ifa.shift_state);
        else pass_cnt = pass_cnt + 1;
        if (ifa.fifo_used !== 4'd0) $display("FAIL rst_used: got %0d expected 0", ifa.fifo_used);
        else pass_cnt = pass_cnt + 1;
        if (ifa.req_ready !== 3'b000) $display("FAIL rst_ready: got %b expected 000", ifa.req_ready);
        else pass_cnt = pass_cnt + 1;
        ifa.req_valid = 3'b000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single;
        set_src_a(1, 7'h2A, 4'h3);
        ifa.req_valid = 3'b010;
        qa.push_back({7'h2A, 4'h3});
        @(negedge clk);
        total_cnt = total_cnt + 1;
        if (ifa.req_ready !== 3'b010) $display("FAIL single_ready: got %b expected 010", ifa.req_ready);
        else pass_cnt = pass_cnt + 1;
        tick();
        ifa.req_valid = 3'b000;
        @(negedge clk);
        total_cnt = total_cnt + 2;
        if (ifa.keypress !== 1'b1) $display("FAIL single_keypress: got %0b expected 1", ifa.keypress);
        else pass_cnt = pass_cnt + 1;
        if (ifa.fifo_used !== 4'd0) $display("FAIL single_used_t1: got %0d expected 0", ifa.fifo_used);
        else pass_cnt = pass_cnt + 1;
        tick();
        @(negedge clk);
        total_cnt = total_cnt + 2;
        if (ifa.fifo_used !== 4'd1) $display("FAIL single_used_t2: got %0d expected 1", ifa.fifo_used);
        else pass_cnt = pass_cnt + 1;
        if (ifa.keypress !== 1'b0) $display("FAIL single_pulse_len: got %0b expected 0", ifa.keypress);
        else pass_cnt = pass_cnt + 1;
        check_empty("single_drain");
        do_reset();
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_r;
        set_src_a(0, 7'h10, 4'h1);
        set_src_a(1, 7'h21, 4'h2);
        set_src_a(2, 7'h32, 4'h4);
        ifa.req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            case (i % 3)
                0: begin exp_r = 3'b100; qa.push_back({7'h10, 4'h1}); end
                1: begin exp_r = 3'b010; qa.push_back({7'h21, 4'h2}); end
                default: begin exp_r = 3'b001; qa.push_back({7'h32, 4'h4}); end
            endcase
            @(negedge clk);
            total_cnt = total_cnt + 1;
            if (ifa.req_ready !== exp_r) $display("FAIL rr_ready_%0d: got %b expected %b", i, ifa.req_ready, exp_r);
            else pass_cnt = pass_cnt + 1;
            tick();
        end
        ifa.req_valid = 3'b000;
        tick();
        check_empty("rr_drain");
        do_reset();
    endtask

    task automatic test_full;
        int kp_cnt;
        set_src_a(0, 7'h45, 4'h5);
        ifa.req_valid = 3'b100;
        for (int i = 0; i < 8; i++) qa.push_back({7'h45, 4'h5});
        kp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifa.keypress) kp_cnt = kp_cnt + 1;
            tick();
        end
        @(negedge clk);
        total_cnt = total_cnt + 3;
        if (kp_cnt != 8) $display("FAIL full_pulses: got %0d expected 8", kp_cnt);
        else pass_cnt = pass_cnt + 1;
        if (ifa.fifo_used !== 4'd8) $display("FAIL full_used: got %0d expected 8", ifa.fifo_used);
        else pass_cnt = pass_cnt + 1;
        if (ifa.req_ready !== 3'b000) $display("FAIL full_ready: got %b expected 000", ifa.req_ready);
        else pass_cnt = pass_cnt + 1;
        tick();
        ifa.fifo_pop = 1'b1;
        qa.push_back({7'h45, 4'h5});
        tick();
        ifa.fifo_pop = 1'b0;
        kp_cnt = 0;
        @(negedge clk);
        total_cnt = total_cnt + 1;
        if (ifa.req_ready !== 3'b100) $display("FAIL full_pop_ready: got %b expected 100", ifa.req_ready);
        else pass_cnt = pass_cnt + 1;
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifa.keypress) kp_cnt = kp_cnt + 1;
            tick();
        end
        @(negedge clk);
        total_cnt = total_cnt + 2;
        if (kp_cnt != 1) $display("FAIL full_pop_pulses: got %0d expected 1", kp_cnt);
        else pass_cnt = pass_cnt + 1;
        if (ifa.fifo_used !== 4'd8) $display("FAIL full_pop_used: got %0d expected 8", ifa.fifo_used);
        else pass_cnt = pass_cnt + 1;
        ifa.req_valid = 3'b000;
        tick();
        check_empty("full_drain");
        do_reset();
    endtask

    task automatic test_gap;
        int last_c;
        int n;
        last_c = -1;
        n = 0;
        ifb.req_keycode[14:20] = 7'h5A;
        ifb.req_shift[8:11]    = 4'hC;
        ifb.req_valid = 3'b001;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifb.keypress) begin
                if (last_c >= 0) begin
                    total_cnt = total_cnt + 1;
                    if (i - last_c != 4) $display("FAIL gap_spacing: got %0d expected 4", i - last_c);
                    else pass_cnt = pass_cnt + 1;
                end
                total_cnt = total_cnt + 1;
                if ({ifb.keycode, ifb.shift_state} !== {7'h5A, 4'hC})
                    $display("FAIL gap_payload: got %0h expected %0h", {ifb.keycode, ifb.shift_state}, {7'h5A, 4'hC});
                else pass_cnt = pass_cnt + 1;
                last_c = i;
                n = n + 1;
            end
            tick();
        end
        ifb.req_valid = 3'b000;
        total_cnt = total_cnt + 1;
        if (n != 5) $display("FAIL gap_count: got %0d expected 5", n);
        else pass_cnt = pass_cnt + 1;
        do_reset();
    endtask

    task automatic test_boundary_pops;
        ifa.fifo_pop = 1'b1;
        tick();
        ifa.fifo_pop = 1'b0;
        @(negedge clk);
        total_cnt = total_cnt + 1;
        if (ifa.fifo_used !== 4'd0) $display("FAIL pop_empty: got %0d expected 0", ifa.fifo_used);
        else pass_cnt = pass_cnt + 1;
        tick();
        set_src_a(0, 7'h11, 4'h6);
        ifa.req_valid = 3'b100;
        for (int i = 0; i < 5; i++) qa.push_back({7'h11, 4'h6});
        repeat (5) tick();
        ifa.req_valid = 3'b000;
        repeat (3) tick();
        @(negedge clk);
        total_cnt = total_cnt + 1;
        if (ifa.fifo_used !== 4'd5) $display("FAIL fill_to_5: got %0d expected 5", ifa.fifo_used);
        else pass_cnt = pass_cnt + 1;
        tick();
        ifa.req_valid = 3'b100;
        qa.push_back({7'h11, 4'h6});
        tick();
        ifa.req_valid = 3'b000;
        ifa.fifo_pop  = 1'b1;
        @(negedge clk);
        total_cnt = total_cnt + 1;
        if ({ifa.keypress, ifa.fifo_used} !== {1'b1, 4'd5})
            $display("FAIL pop_kp5_pre: got kp=%0b used=%0d expected kp=1 used=5", ifa.keypress, ifa.fifo_used);
        else pass_cnt = pass_cnt + 1;
        tick();
        ifa.fifo_pop = 1'b0;
        @(negedge clk);
        total_cnt = total_cnt + 1;
        if (ifa.fifo_used !== 4'd5) $display("FAIL pop_kp_at_5: got %0d expected 5", ifa.fifo_used);
        else pass_cnt = pass_cnt + 1;
        check_empty("pop5_drain");
        do_reset();
        ifa.req_valid = 3'b100;
        qa.push_back({7'h11, 4'h6});
        tick();
        ifa.req_valid = 3'b000;
        ifa.fifo_pop  = 1'b1;
        @(negedge clk);
        total_cnt = total_cnt + 1;
        if ({ifa.keypress, ifa.fifo_used} !== {1'b1, 4'd0})
            $display("FAIL pop_kp0_pre: got kp=%0b used=%0d expected kp=1 used=0", ifa.keypress, ifa.fifo_used);
        else pass_cnt = pass_cnt + 1;
        tick();
        ifa.fifo_pop = 1'b0;
        @(negedge clk);
        total_cnt = total_cnt + 1;
        if (ifa.fifo_used !== 4'd1) $display("FAIL pop_kp_at_0: got %0d expected 1", ifa.fifo_used);
        else pass_cnt = pass_cnt + 1;
        do_reset();
    endtask

    task automatic test_reset_mid_burst;
        set_src_a(0, 7'h61, 4'h7);
        set_src_a(1, 7'h62, 4'h8);
        set_src_a(2, 7'h63, 4'h9);
        ifa.req_valid = 3'b100;
        for (int i = 0; i < 5; i++) qa.push_back({7'h61, 4'h7});
        repeat (5) tick();
        @(negedge clk);
        total_cnt = total_cnt + 1;
        if ({ifa.keypress, ifa.fifo_used} !== {1'b1, 4'd4})
            $display("FAIL burst_pre: got kp=%0b used=%0d expected kp=1 used=4", ifa.keypress, ifa.fifo_used);
        else pass_cnt = pass_cnt + 1;
        #2;
        reset = 1'b1;
        ifa.req_valid = 3'b111;
        #1;
        total_cnt = total_cnt + 2;
        if ({ifa.keypress, ifa.keycode, ifa.shift_state, ifa.fifo_used} !== 16'h0000)
            $display("FAIL burst_rst_outputs: got %0h expected 0",
                     {ifa.keypress, ifa.keycode, ifa.shift_state, ifa.fifo_used});
        else pass_cnt = pass_cnt + 1;
        if (ifa.req_ready !== 3'b000) $display("FAIL burst_rst_ready: got %b expected 000", ifa.req_ready);
        else pass_cnt = pass_cnt + 1;
        check_empty("burst_drain");
        qa.delete();
        tick();
        reset = 1'b0;
        qa.push_back({7'h61, 4'h7});
        @(negedge clk);
        total_cnt = total_cnt + 1;
        if (ifa.req_ready !== 3'b100) $display("FAIL burst_first_winner: got %b expected 100", ifa.req_ready);
        else pass_cnt = pass_cnt + 1;
        tick();
        ifa.req_valid = 3'b000;
        tick();
        check_empty("burst_post_drain");
        do_reset();
    endtask

    initial begin
        clk   = 1'b0;
        reset = 1'b1;
        ifa.req_valid   = 3'b000;
        ifa.req_keycode = 21'd0;
        ifa.req_shift   = 12'd0;
        ifa.fifo_pop    = 1'b0;
        ifb.req_valid   = 3'b000;
        ifb.req_keycode = 21'd0;
        ifb.req_shift   = 12'd0;
        ifb.fifo_pop    = 1'b0;
        repeat (2) tick();
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_gap();
        test_boundary_pops();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
